// File: rtl/window_scan_ctrl_pkg.sv
// rtl/window_scan_ctrl_pkg.sv - shared types and constants for the 3x3 window sequencer
package window_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    // Bit positions inside the {top,bottom,left,right} border mask
    localparam int BORDER_TOP   = 3;
    localparam int BORDER_BOT   = 2;
    localparam int BORDER_LEFT  = 1;
    localparam int BORDER_RIGHT = 0;

    localparam int DEFAULT_WIDTH  = 320;
    localparam int DEFAULT_HEIGHT = 240;

endpackage

// File: rtl/window_scan_ctrl_scan_coord_cnt.sv
// rtl/window_scan_ctrl_scan_coord_cnt.sv - raster column/row counter with wrap and eol/eof flags
module scan_coord_cnt #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int CW     = 9,
    parameter int RW     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          eol,
    output logic          eof
);

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    assign eol = (col == COL_LAST);
    assign eof = eol && (row == ROW_LAST);

    // Step one position in raster order; the last position of a frame wraps to (0,0)
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (eol) begin
                col <= '0;
                row <= eof ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/window_scan_ctrl.sv
// rtl/window_scan_ctrl.sv - line-buffer sequencer producing 3x3 window handshakes with border masks
module window_scan_ctrl
    import window_scan_ctrl_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int HEIGHT = DEFAULT_HEIGHT,
    parameter int CW     = 9,
    parameter int RW     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          buf_shift,
    output logic          buf_zero,
    output logic          win_valid,
    input  logic          win_ready,
    output logic [CW-1:0] out_col,
    output logic [RW-1:0] out_row,
    output logic [3:0]    border,
    output logic          sof,
    output logic          eol,
    output logic          eof
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam int IW   = $clog2(NPIX + 1);
    localparam int FW   = $clog2(WIDTH + 2);

    // The window centre trails the newest pixel by one line plus one pixel
    localparam logic [IW-1:0] FILL_LAST  = IW'(WIDTH + 1);
    localparam logic [IW-1:0] RUN_LAST   = IW'(NPIX);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(WIDTH + 1);

    state_t        state, state_nxt;
    logic [IW-1:0] in_cnt, in_cnt_nxt;
    logic [FW-1:0] flush_cnt, flush_cnt_nxt;
    logic          win_valid_q, win_valid_nxt;
    logic          stall, win_take, accept, flush_step, advance, emit;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          at_eol, at_eof;

    // Handshake decode, line-buffer enables and next-state selection
    always_comb begin
        state_nxt     = state;
        in_cnt_nxt    = in_cnt;
        flush_cnt_nxt = flush_cnt;

        stall      = win_valid_q & ~win_ready;
        win_take   = win_valid_q & win_ready;
        in_ready   = ~rst & ~stall & (state != ST_FLUSH);
        accept     = in_valid & in_ready;
        flush_step = (state == ST_FLUSH) & (flush_cnt != FLUSH_LAST);
        advance    = ~rst & ~stall & (accept | flush_step);
        buf_shift  = advance;
        buf_zero   = advance & (state == ST_FLUSH);
        // Once the buffer is primed every advance completes exactly one window
        emit          = advance & ((state == ST_RUN) | (state == ST_FLUSH));
        win_valid_nxt = emit | stall;

        if (accept) begin
            in_cnt_nxt = in_cnt + IW'(1);
        end
        if (flush_step && advance) begin
            flush_cnt_nxt = flush_cnt + FW'(1);
        end

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                if (accept && in_cnt_nxt == FILL_LAST) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && in_cnt_nxt == RUN_LAST) begin
                    state_nxt     = ST_FLUSH;
                    flush_cnt_nxt = '0;
                end
            end
            ST_FLUSH: begin
                // The last flush step leaves the final window pending; leave once it is taken
                if (flush_cnt == FLUSH_LAST && win_take) begin
                    state_nxt     = ST_IDLE;
                    in_cnt_nxt    = '0;
                    flush_cnt_nxt = '0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, pixel/flush counters and the registered window-valid flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            in_cnt      <= '0;
            flush_cnt   <= '0;
            win_valid_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            in_cnt      <= in_cnt_nxt;
            flush_cnt   <= flush_cnt_nxt;
            win_valid_q <= win_valid_nxt;
        end
    end

    // Coordinates always name the window being presented or the next one to be presented
    scan_coord_cnt #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .CW     (CW),
        .RW     (RW)
    ) u_coord (
        .clk (clk),
        .rst (rst),
        .en  (win_take),
        .col (col),
        .row (row),
        .eol (at_eol),
        .eof (at_eof)
    );

    assign win_valid = win_valid_q;
    assign out_col   = col;
    assign out_row   = row;
    assign eol       = win_valid_q & at_eol;
    assign eof       = win_valid_q & at_eof;
    assign sof       = win_valid_q & (col == '0) & (row == '0);

    // Border mask marks neighbours that fall outside the frame
    always_comb begin
        border = '0;
        if (win_valid_q) begin
            border[BORDER_TOP]   = (row == '0);
            border[BORDER_BOT]   = (row == RW'(HEIGHT - 1));
            border[BORDER_LEFT]  = (col == '0);
            border[BORDER_RIGHT] = at_eol;
        end
    end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// tb/tb_window_scan_ctrl.sv - scoreboard bench for window_scan_ctrl at WIDTH=4, HEIGHT=3
module tb_window_scan_ctrl;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int CW = 2;
    localparam int RW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          win_ready = 1'b1;
    logic          in_ready, buf_shift, buf_zero, win_valid;
    logic [CW-1:0] out_col;
    logic [RW-1:0] out_row;
    logic [3:0]    border;
    logic          sof, eol, eof;

    int errors = 0;
    int checks = 0;
    bit sb_en  = 1'b1;

    typedef struct packed {
        logic [RW-1:0] row;
        logic [CW-1:0] col;
        logic [3:0]    border;
        logic          sof;
        logic          eol;
        logic          eof;
    } win_t;

    win_t sb[$];

    // {top,bottom,left,right} for each centre in raster order
    logic [3:0] exp_border [12] = '{
        4'b1010, 4'b1000, 4'b1000, 4'b1001,
        4'b0010, 4'b0000, 4'b0000, 4'b0001,
        4'b0110, 4'b0100, 4'b0100, 4'b0101
    };

    window_scan_ctrl #(
        .WIDTH  (W),
        .HEIGHT (H),
        .CW     (CW),
        .RW     (RW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .buf_shift (buf_shift),
        .buf_zero  (buf_zero),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .out_col   (out_col),
        .out_row   (out_row),
        .border    (border),
        .sof       (sof),
        .eol       (eol),
        .eof       (eof)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame();
        for (int i = 0; i < W * H; i++) begin
            win_t e;
            e.row    = RW'(i / W);
            e.col    = CW'(i % W);
            e.border = exp_border[i];
            e.sof    = (i == 0);
            e.eol    = ((i % W) == W - 1);
            e.eof    = (i == W * H - 1);
            sb.push_back(e);
        end
    endtask

    // Monitor: every window handshake is compared against the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && sb_en && win_valid && win_ready) begin
            if (sb.size() == 0) begin
                check("extra_window", 32'd1, 32'd0);
            end else begin
                win_t e;
                e = sb.pop_front();
                check("win_row",    32'(out_row), 32'(e.row));
                check("win_col",    32'(out_col), 32'(e.col));
                check("win_border", 32'(border),  32'(e.border));
                check("win_sof",    32'(sof),     32'(e.sof));
                check("win_eol",    32'(eol),     32'(e.eol));
                check("win_eof",    32'(eof),     32'(e.eof));
            end
        end
    end

    task automatic run_frame(input string tag, input int gap, input bit do_stall,
                             input int npix, input bit full);
        int sent = 0;
        int cyc = 0;
        int zeros = 0;
        int shifts = 0;
        int bad = 0;
        int stall_left = 0;
        int acc6 = -1;
        int first_wv = -1;
        bit stalled = 1'b0;
        bit ready_in_flush = 1'b0;
        if (full) push_frame();
        while (1) begin
            if (full && sent == npix && sb.size() == 0 && !win_valid) break;
            if (!full && sent == npix) break;
            if (cyc > 400) begin
                check({tag, "_timeout"}, 32'd1, 32'd0);
                break;
            end
            if (do_stall && !stalled && win_valid && out_row == 1 && out_col == 1) begin
                stalled    = 1'b1;
                stall_left = 3;
            end
            win_ready = (stall_left == 0);
            in_valid  = (sent < npix) && (cyc % gap == 0);
            @(negedge clk);
            if (stall_left > 0) begin
                check({tag, "_stall_valid"}, 32'(win_valid), 32'd1);
                check({tag, "_stall_row"},   32'(out_row),   32'd1);
                check({tag, "_stall_col"},   32'(out_col),   32'd1);
                check({tag, "_stall_shift"}, 32'(buf_shift), 32'd0);
                check({tag, "_stall_ready"}, 32'(in_ready),  32'd0);
                stall_left--;
            end
            if (in_valid && in_ready) begin
                sent++;
                if (sent == W + 2) acc6 = cyc;
            end
            if (win_valid && first_wv < 0) first_wv = cyc;
            if (buf_zero) begin
                zeros++;
                if (in_ready) ready_in_flush = 1'b1;
            end
            if (buf_shift) begin
                shifts++;
                if (!buf_zero && !(in_valid && in_ready)) bad++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        win_ready = 1'b1;
        if (full) begin
            check({tag, "_zero_shifts"},    32'(zeros),           32'(W + 1));
            check({tag, "_total_shifts"},   32'(shifts),          32'(W * H + W + 1));
            check({tag, "_stray_shift"},    32'(bad),             32'd0);
            check({tag, "_ready_in_flush"}, 32'(ready_in_flush),  32'd0);
            check({tag, "_first_win_lag"},  32'(first_wv - acc6), 32'd1);
            check({tag, "_stall_seen"},     32'(stalled),         32'(do_stall));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_win_valid"}, 32'(win_valid), 32'd0);
        check({tag, "_out_col"},   32'(out_col),   32'd0);
        check({tag, "_out_row"},   32'(out_row),   32'd0);
        check({tag, "_border"},    32'(border),    32'd0);
        check({tag, "_sof"},       32'(sof),       32'd0);
        check({tag, "_eol"},       32'(eol),       32'd0);
        check({tag, "_eof"},       32'(eof),       32'd0);
        check({tag, "_buf_shift"}, 32'(buf_shift), 32'd0);
        check({tag, "_buf_zero"},  32'(buf_zero),  32'd0);
    endtask

    initial begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_frame("continuous", 1, 1'b0, W * H, 1'b1);
        run_frame("back_to_back", 1, 1'b0, W * H, 1'b1);
        run_frame("stall", 1, 1'b1, W * H, 1'b1);
        run_frame("gaps", 3, 1'b0, W * H, 1'b1);

        sb_en = 1'b0;
        run_frame("partial", 1, 1'b0, 7, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_shift",    32'(buf_shift), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_rst");
        @(posedge clk);
        #1;
        sb_en = 1'b1;
        run_frame("after_reset", 1, 1'b0, W * H, 1'b1);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
